datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Micro-sequencer that drives the 32-bit control word and 64-bit constant into the LEGv8 datapath-with-memory.
- Accepts one macro-operation at a time over a valid/ready handshake and expands it into 1 or LOAD_CYCLES control-word cycles.
- Pulses done on the final cycle of each operation.
- Sits between the instruction source (decoder or test driver) and the datapath; replaces hand-sequenced control words.

Parameters:
- LOAD_CYCLES, 2, cycles a LDUR holds the memory-read control word; min 2, RegWrite only in the last cycle.
- IMM_W, 12, width of the req_imm field.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  operation request valid
- req_ready  output  1  sequencer can accept a request this cycle
- req_op  input  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 EOR, 6 ADDI, 7 SUBI, 8 ANDI, 9 ORRI, 10 LDUR, 11 STUR, 12 SUBS; 13-15 illegal
- req_rd  input  5  destination register (DA)
- req_rn  input  5  A-source register (SA)
- req_rm  input  5  B-source / store-data register (SB)
- req_imm  input  IMM_W  immediate
- status  input  4  ALU flags {V,C,N,Z}, valid combinationally during the cycle the op's control word is driven
- control_word  output  32  datapath control word (registered)
- constant  output  64  datapath constant (registered)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, final cycle of an op
- err  output  1  one-cycle pulse with done for an illegal opcode
- flags  output  4  latched status (see Optional Feature)

Behaviour:
- Control word layout:
  - [4:0] DA, [9:5] SA, [14:10] SB
  - [15] RegWrite, [16] constant select, [21:17] FS, [22] carry-in, [23] address enable
  - [24] ALU-to-bus, [25] mem write, [26] mem enable, [31:27] aux
- FS codes: AND 00000, ORR 00100, EOR 01100, ADD 01000, SUB 01001.
- SUB, SUBI and SUBS set carry-in=1.
- Reset: state IDLE; control_word=0, constant=0, busy=0, done=0, err=0, flags=0, req_ready=1.
- States:
  - IDLE: control_word=0 (NOP).
  - EXEC: 1 cycle; ALU ops, NOP, illegal.
  - MEM_RD: LOAD_CYCLES cycles.
  - MEM_WR: 1 cycle.
- Accept on a rising edge with req_valid && req_ready; request fields are captured. The op's first control word appears on control_word the cycle after acceptance (latency 1).
- req_ready is high in IDLE and in the final cycle of any op. Back-to-back accepts are allowed, giving zero idle cycles between ops.
- Final cycle with no accept: next state IDLE, control_word returns to 0.
- R-type ops: ALU-to-bus=1, RegWrite=1, constant select=0, aux=0, constant unchanged.
- I-type ops: constant select=1, constant = zero-extended req_imm.
- LDUR:
  - aux=01011, mem enable=1, address enable=1, FS=ADD, constant select=1.
  - constant = sign-extended req_imm[8:0].
  - RegWrite=0 except in the last MEM_RD cycle.
- STUR: aux=00111, mem enable=1, mem write=1, address enable=1, FS=ADD, constant select=1, RegWrite=0, SB=req_rm (data register).
- NOP: control_word=0 for 1 cycle, done=1.
- Illegal op: behaves as NOP with err=1.
- busy is high from the cycle after accept until the final cycle inclusive.
- Reset mid-operation: abort immediately, all outputs return to reset values asynchronously; no partial memory write is issued after reset deassertion.
- req_valid dropping in IDLE has no effect. Request fields are ignored unless accepted.

Optional Feature:
- Macro: DATAPATH_SEQ_FLAGS_EN.
- Defined: SUBS is sequenced as SUB, and at the end of its EXEC cycle flags <= status. flags holds until the next SUBS or reset.
- Undefined: SUBS behaves exactly as SUB; flags is tied to 0.

Test Plan:
- Reset, then ORRI rd=0 rn=31 rm=1 imm=24 -> cycle after accept: control_word=0x010987E0, constant=24, done=1; next cycle control_word=0.
- SUB rd=1 rn=31 rm=0 issued back-to-back after the ORRI -> accepted in the ORRI's final cycle; next cycle control_word=0x015283E1, no NOP cycle between the two ops.
- STUR rn=31 rm=1 imm=24 -> control_word=0x3E9107E0 for 1 cycle, constant=24, done=1.
- LDUR rd=2 rn=31 rm=1 imm=0x1F8 (-8), LOAD_CYCLES=2 -> control_word=0x5C9107E2 then 0x5C9187E2; constant=0xFFFF_FFFF_FFFF_FFF8; done only in the second cycle.
- req_op=14 -> control_word=0 for 1 cycle, done=1 and err=1 together. Reset asserted in the first cycle of an LDUR -> control_word=0 immediately, busy=0, req_ready=1.
- With DATAPATH_SEQ_FLAGS_EN: SUBS with status=4'b0101 -> flags=4'b0101 the cycle after; a following ADD leaves flags unchanged. Without the macro, flags stays 0.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// Request channel into the LEGv8 datapath sequencer.
// One macro-op per valid/ready handshake.
interface datapath_sequencer_if #(
  parameter int IMM_W = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [4:0]       req_rd;
  logic [4:0]       req_rn;
  logic [4:0]       req_rm;
  logic [IMM_W-1:0] req_imm;

  modport master (
    output req_valid, req_op, req_rd,
    output req_rn, req_rm, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_rd,
    input  req_rn, req_rm, req_imm,
    output req_ready
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Expands macro-ops into LEGv8 datapath control words.
// Define DATAPATH_SEQ_FLAGS_EN to latch ALU status on SUBS.
module datapath_sequencer #(
  parameter int LOAD_CYCLES = 2,
  parameter int IMM_W       = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  datapath_sequencer_if.slave        req,
  input  logic [3:0]                 status,
  output logic [31:0]                control_word,
  output logic [63:0]                constant,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [3:0]                 flags
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MEM_RD,
    MEM_WR
  } state_e;

  localparam int CNT_W = $clog2(LOAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_ORR  = 4'd4;
  localparam logic [3:0] OP_EOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;
  localparam logic [3:0] OP_ANDI = 4'd8;
  localparam logic [3:0] OP_ORRI = 4'd9;
  localparam logic [3:0] OP_LDUR = 4'd10;
  localparam logic [3:0] OP_STUR = 4'd11;
  localparam logic [3:0] OP_SUBS = 4'd12;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [4:0] AUX_LD = 5'b01011;
  localparam logic [4:0] AUX_ST = 5'b00111;

  state_e           state_q, state_d;
  logic [31:0]      cw_q, cw_d;
  logic [63:0]      k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic        accept;
  logic        is_alu;
  logic        is_imm;
  logic        is_ld;
  logic        is_st;
  logic [4:0]  fs;
  logic        cin;
  logic [63:0] imm_z;
  logic [63:0] imm_s;

  assign req.req_ready = (state_q == IDLE) || done_q;
  assign accept = req.req_valid && req.req_ready;

  assign is_alu = ((req.req_op >= OP_ADD) && (req.req_op <= OP_ORRI))
               || (req.req_op == OP_SUBS);
  assign is_imm = (req.req_op >= OP_ADDI) && (req.req_op <= OP_ORRI);
  assign is_ld  = req.req_op == OP_LDUR;
  assign is_st  = req.req_op == OP_STUR;

  assign imm_z = 64'(req.req_imm);
  assign imm_s = {{55{req.req_imm[8]}}, req.req_imm[8:0]};

  always_comb begin
    fs  = FS_ADD;
    cin = 1'b0;
    case (req.req_op)
      OP_SUB, OP_SUBI, OP_SUBS: begin
        fs  = FS_SUB;
        cin = 1'b1;
      end
      OP_AND, OP_ANDI: fs = FS_AND;
      OP_ORR, OP_ORRI: fs = FS_ORR;
      OP_EOR:          fs = FS_EOR;
      default:         fs = FS_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      cw_d        = '0;
      cw_d[14:0]  = {req.req_rm, req.req_rn, req.req_rd};
      cnt_d       = '0;
      done_d      = 1'b1;
      unique case (1'b1)
        is_alu: begin
          state_d     = EXEC;
          cw_d[24]    = 1'b1;
          cw_d[22]    = cin;
          cw_d[21:17] = fs;
          cw_d[16]    = is_imm;
          cw_d[15]    = 1'b1;
          if (is_imm) k_d = imm_z;
        end
        is_ld: begin
          state_d     = MEM_RD;
          cw_d[31:27] = AUX_LD;
          cw_d[26]    = 1'b1;
          cw_d[23]    = 1'b1;
          cw_d[21:17] = FS_ADD;
          cw_d[16]    = 1'b1;
          k_d         = imm_s;
          done_d      = 1'b0;
        end
        is_st: begin
          state_d     = MEM_WR;
          cw_d[31:27] = AUX_ST;
          cw_d[26]    = 1'b1;
          cw_d[25]    = 1'b1;
          cw_d[23]    = 1'b1;
          cw_d[21:17] = FS_ADD;
          cw_d[16]    = 1'b1;
          k_d         = imm_s;
        end
        default: begin
          state_d = EXEC;
          cw_d    = '0;
          err_d   = req.req_op > OP_SUBS;
        end
      endcase
    end else if ((state_q == MEM_RD) && !done_q) begin
      // Hold the read word; write back only in the last cycle.
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == LAST) begin
        cw_d[15] = 1'b1;
        done_d   = 1'b1;
      end
    end else begin
      state_d = IDLE;
      cw_d    = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cw_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign control_word = cw_q;
  assign constant     = k_q;
  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign err          = err_q;

`ifdef DATAPATH_SEQ_FLAGS_EN
  logic       subs_q, subs_d;
  logic [3:0] flags_q, flags_d;

  always_comb begin
    subs_d  = accept && (req.req_op == OP_SUBS);
    flags_d = flags_q;
    if ((state_q == EXEC) && subs_q) flags_d = status;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      subs_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      subs_q  <= subs_d;
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  logic unused_status;
  assign unused_status = ^status;
  assign flags = 4'b0;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized bench for datapath_sequencer against a cycle-list model.
// Define DATAPATH_SEQ_FLAGS_EN to match a flags-enabled build.
module tb_datapath_sequencer;
  localparam int LC = 2;
  localparam int IW = 12;
`ifdef DATAPATH_SEQ_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  status;
  logic [31:0] control_word;
  logic [63:0] constant;
  logic        busy, done, err;
  logic [3:0]  flags;

  datapath_sequencer_if #(.IMM_W(IW)) rq();

  datapath_sequencer #(.LOAD_CYCLES(LC), .IMM_W(IW)) dut (
    .clock(clock),
    .reset(reset),
    .req(rq),
    .status(status),
    .control_word(control_word),
    .constant(constant),
    .busy(busy),
    .done(done),
    .err(err),
    .flags(flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] cw;
    logic [63:0] k;
    bit busy;
    bit done;
    bit err;
    bit subs;
  } cyc_t;

  cyc_t       cur;
  cyc_t       pend[$];
  logic [3:0] flags_m;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] cword(
    input int aux, input bit men, input bit mwr, input bit abus,
    input bit aen, input bit cin, input int fs, input bit csel,
    input bit rw, input logic [4:0] sb, input logic [4:0] sa,
    input logic [4:0] da);
    return {5'(aux), men, mwr, abus, aen, cin, 5'(fs), csel, rw,
            sb, sa, da};
  endfunction

  function automatic void model_reset();
    pend.delete();
    cur.cw = 0; cur.k = 0; cur.busy = 0;
    cur.done = 0; cur.err = 0; cur.subs = 0;
    flags_m = 0;
  endfunction

  function automatic void expand(input logic [3:0] op,
    input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
    input logic [IW-1:0] imm);
    cyc_t c;
    int fs, i9;
    bit cin, isimm;
    logic [63:0] sx;
    c.k = cur.k; c.busy = 1; c.done = 1; c.err = 0; c.subs = 0;
    c.cw = 0;
    fs = 8; cin = 0;
    if (op == 2 || op == 7 || op == 12) begin fs = 9; cin = 1; end
    if (op == 3 || op == 8) fs = 0;
    if (op == 4 || op == 9) fs = 4;
    if (op == 5) fs = 12;
    i9 = int'(imm[8:0]);
    sx = (i9 >= 256) ? 64'(i9) - 64'd512 : 64'(i9);
    isimm = (op >= 6 && op <= 9);
    if ((op >= 1 && op <= 9) || op == 12) begin
      c.cw = cword(0, 0, 0, 1, 0, cin, fs, isimm, 1, rm, rn, rd);
      if (isimm) c.k = 64'(imm);
      c.subs = (op == 12);
      pend.push_back(c);
    end else if (op == 10) begin
      for (int i = 0; i < LC; i++) begin
        c.k = sx;
        c.cw = cword(11, 1, 0, 0, 1, 0, 8, 1, i == LC - 1, rm, rn, rd);
        c.done = (i == LC - 1);
        pend.push_back(c);
      end
    end else if (op == 11) begin
      c.k = sx;
      c.cw = cword(7, 1, 1, 0, 1, 0, 8, 1, 0, rm, rn, rd);
      pend.push_back(c);
    end else begin
      c.err = (op > 12);
      pend.push_back(c);
    end
  endfunction

  function automatic void advance(input bit acc, input logic [3:0] op,
    input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
    input logic [IW-1:0] imm, input logic [3:0] st);
    if (cur.subs && FLAGS_EN) flags_m = st;
    if (acc) expand(op, rd, rn, rm, imm);
    if (pend.size() > 0) cur = pend.pop_front();
    else begin
      cur.cw = 0; cur.busy = 0; cur.done = 0;
      cur.err = 0; cur.subs = 0;
    end
  endfunction

  task automatic compare();
    chk("control_word", 64'(control_word), 64'(cur.cw));
    chk("constant", constant, cur.k);
    chk("busy", 64'(busy), 64'(cur.busy));
    chk("done", 64'(done), 64'(cur.done));
    chk("err", 64'(err), 64'(cur.err));
    chk("req_ready", 64'(rq.req_ready), 64'(!cur.busy || cur.done));
    chk("flags", 64'(flags), 64'(flags_m));
  endtask

  task automatic step(input bit v, input logic [3:0] op,
    input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
    input logic [IW-1:0] imm, input logic [3:0] st);
    bit acc;
    rq.req_valid = v;
    rq.req_op = op;
    rq.req_rd = rd;
    rq.req_rn = rn;
    rq.req_rm = rm;
    rq.req_imm = imm;
    status = st;
    acc = v && (!cur.busy || cur.done);
    @(posedge clock);
    advance(acc, op, rd, rn, rm, imm, st);
    @(negedge clock);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           IW'($urandom), 4'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    status = '0;
    rq.req_valid = 1'b0;
    rq.req_op = '0;
    rq.req_rd = '0;
    rq.req_rn = '0;
    rq.req_rm = '0;
    rq.req_imm = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_cw", 64'(control_word), 64'h0);
    chk("rst_const", constant, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);
    chk("rst_ready", 64'(rq.req_ready), 64'h1);
    reset = 1'b0;

    step(1, 4'd9, 5'd0, 5'd31, 5'd1, IW'(24), 4'd0);
    chk("orri_cw", 64'(control_word), 64'h010987E0);
    chk("orri_const", constant, 64'd24);
    chk("orri_done", 64'(done), 64'h1);
    step(1, 4'd2, 5'd1, 5'd31, 5'd0, IW'($urandom), 4'd0);
    chk("sub_cw", 64'(control_word), 64'h015283E1);
    chk("sub_const", constant, 64'd24);
    idle(1);
    chk("idle_cw", 64'(control_word), 64'h0);

    step(1, 4'd11, 5'd0, 5'd31, 5'd1, IW'(24), 4'd0);
    chk("stur_cw", 64'(control_word), 64'h3E9107E0);
    chk("stur_const", constant, 64'd24);
    chk("stur_done", 64'(done), 64'h1);

    step(1, 4'd10, 5'd2, 5'd31, 5'd1, IW'(12'h1F8), 4'd0);
    chk("ldur_cw0", 64'(control_word), 64'h5C9107E2);
    chk("ldur_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_done0", 64'(done), 64'h0);
    idle(1);
    chk("ldur_cw1", 64'(control_word), 64'h5C9187E2);
    chk("ldur_done1", 64'(done), 64'h1);

    step(1, 4'd14, 5'd3, 5'd4, 5'd5, IW'(7), 4'd0);
    chk("ill_cw", 64'(control_word), 64'h0);
    chk("ill_done", 64'(done), 64'h1);
    chk("ill_err", 64'(err), 64'h1);

    step(1, 4'd12, 5'd3, 5'd4, 5'd5, IW'(0), 4'd0);
    step(1, 4'd1, 5'd6, 5'd7, 5'd8, IW'(0), 4'b0101);
    chk("subs_flags", 64'(flags), FLAGS_EN ? 64'h5 : 64'h0);
    step(0, 4'd0, 5'd0, 5'd0, 5'd0, IW'(0), 4'b1010);
    chk("flags_hold", 64'(flags), FLAGS_EN ? 64'h5 : 64'h0);

    step(1, 4'd10, 5'd9, 5'd10, 5'd11, IW'(3), 4'd0);
    #2 reset = 1'b1;
    #1;
    chk("abort_cw", 64'(control_word), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_ready", 64'(rq.req_ready), 64'h1);
    chk("abort_const", constant, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(3);

    step(1, 4'd11, 5'd1, 5'd2, 5'd3, IW'(5), 4'd0);
    #2 reset = 1'b1;
    #1;
    chk("abort_st_cw", 64'(control_word), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(2);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), IW'($urandom), 4'($urandom));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
